// File: rtl/cache_arb_pkg.sv
// Shared types for the cache port arbiter.
//   state_e   : arbiter FSM states
//   op_e      : request type carried through an operation
//   wd_width  : width of the write watchdog counter for a given timeout
package cache_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAP   = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selector, purely combinational.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (0 when no request)
//   idx : binary index of the granted requester
//   any : at least one request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from ptr upward, wrapping; the first set bit wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one CLOCK-replacement line cache between N_REQ requesters.
// One operation in flight; round-robin grant; single-cycle response pulse
// back to the requester that issued the operation.
//   clock, reset           : clock, synchronous active-high reset
//   req_valid/ready/write  : per-requester handshake and op type
//   req_addr, req_data     : flattened per-requester address / write data
//   resp_valid             : one-hot response pulse to the issuing requester
//   resp_hit/err/data      : response payload (shared by all requesters)
//   cache_read/write       : strobes to the cache
//   cache_addr/val         : address / write line to the cache
//   cache_hit, cache_out   : registered lookup result from the cache
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int K          = 2,
  parameter int WR_TIMEOUT = 4 * K + 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*LINE_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            resp_valid,
  output logic                        resp_hit,
  output logic                        resp_err,
  output logic [LINE_WIDTH-1:0]       resp_data,
  output logic                        cache_read,
  output logic                        cache_write,
  output logic [ADDR_WIDTH-1:0]       cache_addr,
  output logic [LINE_WIDTH-1:0]       cache_val,
  input  logic                        cache_hit,
  input  logic [LINE_WIDTH-1:0]       cache_out
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W = wd_width(WR_TIMEOUT);

  state_e                  state_q, state_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    whit_q, whit_d;
  logic                    cache_read_q, cache_read_d;
  logic                    cache_write_q, cache_write_d;
  logic [ADDR_WIDTH-1:0]   cache_addr_q, cache_addr_d;
  logic [LINE_WIDTH-1:0]   cache_val_q, cache_val_d;
  logic [N_REQ-1:0]        resp_valid_q, resp_valid_d;
  logic                    resp_hit_q, resp_hit_d;
  logic                    resp_err_q, resp_err_d;
  logic [LINE_WIDTH-1:0]   resp_data_q, resp_data_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  op_e              gnt_op;
  logic             wd_expired;
  logic             wr_done;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign gnt_op     = req_write[gnt_idx] ? OP_WRITE : OP_READ;
  assign wd_expired = (wd_q == WD_W'(WR_TIMEOUT - 1));
  // A hit on the final watchdog cycle still counts as a completed write.
  assign wr_done    = cache_hit || wd_expired;

  // Only IDLE accepts; masked during reset so outputs read 0 while held.
  assign req_ready = (state_q == IDLE && !reset) ? gnt : '0;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      wd_q          <= '0;
      whit_q        <= 1'b0;
      cache_read_q  <= 1'b0;
      cache_write_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_val_q   <= '0;
      resp_valid_q  <= '0;
      resp_hit_q    <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      wd_q          <= wd_d;
      whit_q        <= whit_d;
      cache_read_q  <= cache_read_d;
      cache_write_q <= cache_write_d;
      cache_addr_q  <= cache_addr_d;
      cache_val_q   <= cache_val_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_err_q    <= resp_err_d;
      resp_data_q   <= resp_data_d;
    end
  end

  // Next-state
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    wd_d     = wd_q;
    whit_d   = whit_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d  = (gnt_op == OP_WRITE) ? WR_ISSUE : RD_ISSUE;
          owner_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      RD_ISSUE: state_d = RD_CAP;
      RD_CAP:   state_d = RESP;
      WR_ISSUE: begin
        state_d = WR_WAIT;
        wd_d    = '0;
      end
      WR_WAIT: begin
        // First WR_WAIT cycle shows whether the line was already present.
        if (wd_q == '0) whit_d = cache_hit;
        if (wr_done) state_d = RESP;
        else         wd_d    = wd_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs
  always_comb begin
    cache_read_d  = 1'b0;
    cache_write_d = 1'b0;
    cache_addr_d  = cache_addr_q;
    cache_val_d   = cache_val_q;
    resp_valid_d  = '0;
    resp_hit_d    = 1'b0;
    resp_err_d    = 1'b0;
    resp_data_d   = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          cache_read_d  = (gnt_op == OP_READ);
          cache_write_d = (gnt_op == OP_WRITE);
          cache_addr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          cache_val_d   = req_data[gnt_idx*LINE_WIDTH +: LINE_WIDTH];
        end
      end
      WR_ISSUE: cache_write_d = 1'b1;
      WR_WAIT: begin
        // The strobe is still high on the exit cycle, so the cache sees one
        // extra same-address write; that rewrite is harmless.
        if (!wr_done) begin
          cache_write_d = 1'b1;
        end else begin
          resp_valid_d[owner_q] = 1'b1;
          resp_hit_d            = (wd_q == '0) ? cache_hit : whit_q;
          resp_err_d            = !cache_hit;
        end
      end
      RD_CAP: begin
        resp_valid_d[owner_q] = 1'b1;
        resp_hit_d            = cache_hit;
        resp_data_d           = cache_hit ? cache_out : '0;
      end
      default: ;
    endcase
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_err    = resp_err_q;
  assign resp_data   = resp_data_q;
  assign cache_read  = cache_read_q;
  assign cache_write = cache_write_q;
  assign cache_addr  = cache_addr_q;
  assign cache_val   = cache_val_q;

endmodule
